// File: rtl/scsp_midi_tx.sv
// MIDI OUT transmitter: MOBUF writes are queued in a small FIFO and shifted out as
// 8N1 frames on txd_o. Reports FIFO empty/full status and pulses mo_int_o when the
// last queued byte has finished its stop bit.
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   ce_i        clock enable; all state advances only on enabled edges
//   mobuf_wr_i  one-cycle write strobe for MOBUF
//   mobuf_di_i  byte to queue for transmission
//   oe_o        FIFO empty
//   of_o        FIFO full
//   busy_o      a frame is being shifted out
//   mo_int_o    one-CE-cycle pulse when the queue drains after a stop bit
//   txd_o       serial output, idle high
module scsp_midi_tx #(
  parameter int unsigned BitDiv    = 722,
  parameter int unsigned DepthLog2 = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic       mobuf_wr_i,
  input  logic [7:0] mobuf_di_i,
  output logic       oe_o,
  output logic       of_o,
  output logic       busy_o,
  output logic       mo_int_o,
  output logic       txd_o
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam logic [DepthLog2:0] FullCnt = (DepthLog2 + 1)'(Depth);
  localparam logic [9:0] LastCnt = 10'(BitDiv - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]           mem_q [Depth];
  logic [DepthLog2-1:0] wptr_q, rptr_q;
  logic [DepthLog2:0]   count_q, count_d;
  logic                 oe_q, of_q;

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       txd_q, txd_d;
  logic       mo_int_q, mo_int_d;

  logic pop, push, full, bit_end;

  assign full    = (count_q == FullCnt);
  assign bit_end = (cnt_q == LastCnt);
  // A pop in the same cycle frees a slot, so a write to a full FIFO is accepted then.
  assign push    = ce_i & mobuf_wr_i & (~full | pop);

  always_comb begin
    count_d = count_q;
    if (ce_i) begin
      if (push && !pop) begin
        count_d = count_q + (DepthLog2 + 1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (DepthLog2 + 1)'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    mo_int_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (count_q != '0) begin
            // Next byte queued: start bit follows the stop bit with no idle gap.
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = StStart;
          end else begin
            state_d  = StIdle;
            mo_int_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level for the next period, registered so txd_o never glitches.
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= mobuf_di_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      oe_q     <= 1'b1;
      of_q     <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      mo_int_q <= 1'b0;
    end else if (ce_i) begin
      if (push) begin
        wptr_q <= wptr_q + DepthLog2'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + DepthLog2'(1);
      end
      count_q  <= count_d;
      oe_q     <= (count_d == '0);
      of_q     <= (count_d == FullCnt);
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      mo_int_q <= mo_int_d;
    end
  end

  assign oe_o     = oe_q;
  assign of_o     = of_q;
  assign busy_o   = (state_q != StIdle);
  assign mo_int_o = mo_int_q;
  assign txd_o    = txd_q;

endmodule

// File: tb/tb_scsp_midi_tx.sv
// Directed bench for scsp_midi_tx with BitDiv=4 and a 4-entry FIFO.
// Inputs are driven on the falling edge from per-cycle schedule arrays; outputs
// are logged on the same falling edge just before the new drive is applied, so
// log[i] reflects the DUT after the (i-1)th rising edge of a run.
module tb_scsp_midi_tx;

  localparam int N = 300;

  logic       clk, rst_n, ce, wr;
  logic [7:0] di;
  logic       oe_s, of_s, busy_s, mo_int_s, txd_s;

  int errors = 0;
  int checks = 0;

  logic       s_wr [N];
  logic [7:0] s_di [N];
  logic       s_ce [N];
  logic       l_txd [N];
  logic       l_oe [N];
  logic       l_of [N];
  logic       l_busy [N];
  logic       l_int [N];

  scsp_midi_tx #(
    .BitDiv   (4),
    .DepthLog2(2)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .ce_i      (ce),
    .mobuf_wr_i(wr),
    .mobuf_di_i(di),
    .oe_o      (oe_s),
    .of_o      (of_s),
    .busy_o    (busy_s),
    .mo_int_o  (mo_int_s),
    .txd_o     (txd_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < N; i++) begin
      s_wr[i] = 1'b0;
      s_di[i] = 8'h00;
      s_ce[i] = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      l_txd[i]  = txd_s;
      l_oe[i]   = oe_s;
      l_of[i]   = of_s;
      l_busy[i] = busy_s;
      l_int[i]  = mo_int_s;
      wr = s_wr[i];
      di = s_di[i];
      ce = s_ce[i];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (txd_s !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd_s); end
    checks++; if (oe_s !== 1'b1) begin errors++; $display("FAIL reset_oe: got %b want 1", oe_s); end
    checks++; if (of_s !== 1'b0) begin errors++; $display("FAIL reset_of: got %b want 0", of_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_s); end
    checks++; if (mo_int_s !== 1'b0) begin errors++; $display("FAIL reset_int: got %b want 0", mo_int_s); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] b = 8'h90;
    clear_sched();
    s_wr[0] = 1'b1; s_di[0] = b;
    run(46);
    checks++; if (l_oe[0] !== 1'b1) begin errors++; $display("FAIL single_oe_pre: got %b want 1", l_oe[0]); end
    checks++; if (l_oe[1] !== 1'b0) begin errors++; $display("FAIL single_oe_wr: got %b want 0", l_oe[1]); end
    checks++; if (l_busy[1] !== 1'b0) begin errors++; $display("FAIL single_busy_wr: got %b want 0", l_busy[1]); end
    checks++; if (l_oe[2] !== 1'b1) begin errors++; $display("FAIL single_oe_pop: got %b want 1", l_oe[2]); end
    checks++; if (l_busy[2] !== 1'b1) begin errors++; $display("FAIL single_busy_tx: got %b want 1", l_busy[2]); end
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (l_txd[2+k] !== frame_bit(b, k / 4)) begin
        errors++; $display("FAIL single_txd[%0d]: got %b want %b", k, l_txd[2+k], frame_bit(b, k / 4));
      end
    end
    for (int i = 2; i < 42; i++) begin
      checks++; if (l_int[i] !== 1'b0) begin errors++; $display("FAIL single_int_early[%0d]: got %b want 0", i, l_int[i]); end
    end
    checks++; if (l_int[42] !== 1'b1) begin errors++; $display("FAIL single_int: got %b want 1", l_int[42]); end
    checks++; if (l_int[43] !== 1'b0) begin errors++; $display("FAIL single_int_off: got %b want 0", l_int[43]); end
    checks++; if (l_busy[42] !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", l_busy[42]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes[0] = 8'h90; bytes[1] = 8'h3C; bytes[2] = 8'h7F;
    clear_sched();
    for (int i = 0; i < 3; i++) begin s_wr[i] = 1'b1; s_di[i] = bytes[i]; end
    run(126);
    for (int k = 0; k < 120; k++) begin
      checks++;
      if (l_txd[2+k] !== frame_bit(bytes[k/40], (k % 40) / 4)) begin
        errors++; $display("FAIL b2b_txd[%0d]: got %b want %b", k, l_txd[2+k], frame_bit(bytes[k/40], (k % 40) / 4));
      end
      checks++; if (l_int[2+k] !== 1'b0) begin errors++; $display("FAIL b2b_int_early[%0d]: got %b want 0", k, l_int[2+k]); end
    end
    checks++; if (l_int[122] !== 1'b1) begin errors++; $display("FAIL b2b_int: got %b want 1", l_int[122]); end
    checks++; if (l_busy[122] !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", l_busy[122]); end
  endtask

  task automatic test_overflow();
    clear_sched();
    for (int i = 0; i < 6; i++) begin s_wr[i] = 1'b1; s_di[i] = 8'(i + 1); end
    run(246);
    checks++; if (l_of[4] !== 1'b0) begin errors++; $display("FAIL ovf_of_3: got %b want 0", l_of[4]); end
    checks++; if (l_of[5] !== 1'b1) begin errors++; $display("FAIL ovf_of_full: got %b want 1", l_of[5]); end
    checks++; if (l_of[6] !== 1'b1) begin errors++; $display("FAIL ovf_of_drop: got %b want 1", l_of[6]); end
    checks++; if (l_of[42] !== 1'b0) begin errors++; $display("FAIL ovf_of_pop: got %b want 0", l_of[42]); end
    for (int k = 0; k < 200; k++) begin
      checks++;
      if (l_txd[2+k] !== frame_bit(8'(k / 40 + 1), (k % 40) / 4)) begin
        errors++; $display("FAIL ovf_txd[%0d]: got %b want %b", k, l_txd[2+k], frame_bit(8'(k / 40 + 1), (k % 40) / 4));
      end
    end
    checks++; if (l_int[202] !== 1'b1) begin errors++; $display("FAIL ovf_int: got %b want 1", l_int[202]); end
    for (int i = 202; i < 246; i++) begin
      checks++; if (l_txd[i] !== 1'b1) begin errors++; $display("FAIL ovf_idle[%0d]: got %b want 1", i, l_txd[i]); end
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] bytes [6];
    for (int i = 0; i < 5; i++) bytes[i] = 8'(i + 1);
    bytes[5] = 8'hA5;
    clear_sched();
    for (int i = 0; i < 5; i++) begin s_wr[i] = 1'b1; s_di[i] = bytes[i]; end
    s_wr[41] = 1'b1; s_di[41] = 8'hA5;  // lands on the stop-end pop edge
    run(250);
    checks++; if (l_of[41] !== 1'b1) begin errors++; $display("FAIL fpop_of_before: got %b want 1", l_of[41]); end
    checks++; if (l_of[42] !== 1'b1) begin errors++; $display("FAIL fpop_of_after: got %b want 1", l_of[42]); end
    for (int k = 0; k < 240; k++) begin
      checks++;
      if (l_txd[2+k] !== frame_bit(bytes[k/40], (k % 40) / 4)) begin
        errors++; $display("FAIL fpop_txd[%0d]: got %b want %b", k, l_txd[2+k], frame_bit(bytes[k/40], (k % 40) / 4));
      end
    end
    checks++; if (l_int[202] !== 1'b0) begin errors++; $display("FAIL fpop_int_early: got %b want 0", l_int[202]); end
    checks++; if (l_int[242] !== 1'b1) begin errors++; $display("FAIL fpop_int: got %b want 1", l_int[242]); end
  endtask

  task automatic test_ce_gating();
    logic [7:0] b = 8'h90;
    clear_sched();
    for (int i = 0; i < N; i++) s_ce[i] = (i % 2 == 0);
    s_wr[0] = 1'b1; s_di[0] = b;
    s_wr[1] = 1'b1; s_di[1] = 8'hFF;  // presented with CE low, must be ignored
    run(100);
    checks++; if (l_oe[2] !== 1'b0) begin errors++; $display("FAIL ce_oe_wr: got %b want 0", l_oe[2]); end
    checks++; if (l_oe[3] !== 1'b1) begin errors++; $display("FAIL ce_oe_pop: got %b want 1", l_oe[3]); end
    for (int k = 0; k < 80; k++) begin
      checks++;
      if (l_txd[3+k] !== frame_bit(b, k / 8)) begin
        errors++; $display("FAIL ce_txd[%0d]: got %b want %b", k, l_txd[3+k], frame_bit(b, k / 8));
      end
    end
    checks++; if (l_int[82] !== 1'b0) begin errors++; $display("FAIL ce_int_early: got %b want 0", l_int[82]); end
    checks++; if (l_int[83] !== 1'b1) begin errors++; $display("FAIL ce_int: got %b want 1", l_int[83]); end
    checks++; if (l_int[84] !== 1'b1) begin errors++; $display("FAIL ce_int_hold: got %b want 1", l_int[84]); end
    checks++; if (l_int[85] !== 1'b0) begin errors++; $display("FAIL ce_int_off: got %b want 0", l_int[85]); end
    for (int i = 85; i < 100; i++) begin
      checks++; if (l_txd[i] !== 1'b1) begin errors++; $display("FAIL ce_idle[%0d]: got %b want 1", i, l_txd[i]); end
    end
    clear_sched();
    run(2);
  endtask

  task automatic test_reset_mid_frame();
    clear_sched();
    s_wr[0] = 1'b1; s_di[0] = 8'h00;
    s_wr[1] = 1'b1; s_di[1] = 8'h00;
    run(12);
    checks++; if (l_txd[11] !== 1'b0) begin errors++; $display("FAIL rmid_data: got %b want 0", l_txd[11]); end
    checks++; if (l_oe[11] !== 1'b0) begin errors++; $display("FAIL rmid_queued: got %b want 0", l_oe[11]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (txd_s !== 1'b1) begin errors++; $display("FAIL rmid_txd: got %b want 1", txd_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy_s); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_sched();
    run(20);
    for (int i = 0; i < 20; i++) begin
      checks++; if (l_txd[i] !== 1'b1) begin errors++; $display("FAIL rmid_idle[%0d]: got %b want 1", i, l_txd[i]); end
      checks++; if (l_oe[i] !== 1'b1) begin errors++; $display("FAIL rmid_oe[%0d]: got %b want 1", i, l_oe[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;
    wr    = 1'b0;
    di    = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_ce_gating();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scsp_midi_tx.md
# scsp_midi_tx

MIDI output transmitter for the SCSP. It is the send-side counterpart of the MIDI input path (MIBUF/IE/IF/IO in CR2). Sound-CPU writes to MOBUF (CR3, 0x100406) go into a small FIFO. The FIFO is serialized as 8N1 asynchronous frames on the MIDI OUT line. The block reports the CR2 status bits OE/OF and raises a pulse for the interrupt controller when the output queue drains.

## Interface
- BIT_DIV, default 722: CE-qualified cycles per serial bit (22.5792 MHz / 31250 baud, rounded down). Legal range is 2..1023.
- DEPTH_LOG2, default 2: FIFO depth is 2^DEPTH_LOG2 entries (default 4).
- CLK, in, 1: system clock. Single clock domain.
- RST_N, in, 1: asynchronous, active-low reset.
- CE, in, 1: clock enable. All state advances only on CLK edges where CE=1.
- MOBUF_WR, in, 1: write strobe from the CR3 register decode, one cycle wide.
- MOBUF_DI, in, 8: byte to transmit (CR3.MOBUF).
- OE, out, 1: output FIFO empty (CR2.OE).
- OF, out, 1: output FIFO full (CR2.OF).
- BUSY, out, 1: a frame is being shifted out (state is not IDLE).
- MO_INT, out, 1: one-cycle pulse when the last queued byte finishes its stop bit and the FIFO is empty.
- TXD, out, 1: serial MIDI OUT. Idle level is 1.

## Operation
- Reset values: TXD=1, OE=1, OF=0, BUSY=0, MO_INT=0. FIFO pointers=0. State=IDLE. Bit-period counter=0, bit index=0.
- FIFO:
  - Circular buffer with read/write pointers of DEPTH_LOG2 bits and a count of DEPTH_LOG2+1 bits.
  - OE = (count==0). OF = (count==2^DEPTH_LOG2). Both are registered from the count, so they reflect the state after the last CE edge.
  - A write with CE=1 and MOBUF_WR=1 stores MOBUF_DI at the write pointer and increments the pointer (wraps modulo depth), unless the FIFO is full.
  - A write to a full FIFO is dropped. Stored data and pointers are unchanged, and OF stays 1. This block has no overflow flag.
  - Simultaneous write and pop in one CE cycle: both happen and count is unchanged. This also applies when the FIFO is full, because the pop frees the slot in the same cycle, so the write is accepted.
- Transmit FSM (only advances when CE=1):
  - IDLE: TXD=1. If the FIFO is non-empty: pop into an 8-bit shift register, clear the counter, go to START.
  - START: TXD=0 for BIT_DIV cycles, then go to DATA with bit index 0.
  - DATA: TXD=shift[0], LSB first. After BIT_DIV cycles, shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: TXD=1 for BIT_DIV cycles. At the end of the period:
    - If the FIFO is non-empty: pop and go directly to START (back-to-back frames, no extra idle).
    - Otherwise: go to IDLE and assert MO_INT for that single CE cycle.
- The bit-period counter counts 0..BIT_DIV-1. Reaching BIT_DIV-1 on a CE cycle ends the bit.
- TXD is driven from a register, so it is glitch-free.
- Reset asserted mid-frame aborts the frame immediately and asynchronously: TXD=1 and the FIFO contents are discarded. No partial frame resumes after reset.

## Timing
- Write-to-status: after the CE edge that accepts a write into an empty FIFO, OE=0.
- First pop: on the next CE edge while IDLE, the byte is popped and the state becomes START. TXD falls at that edge, so there are 2 CE cycles from MOBUF_WR to the TXD falling edge.
- OE returns to 1 at the pop edge, not at the end of the frame. BUSY stays 1 until the stop bit completes.
- Frame length is exactly 10×BIT_DIV CE cycles. Back-to-back frames have zero gap.
- MO_INT is asserted for exactly one CE-qualified cycle, coincident with the STOP→IDLE transition. It is not asserted at STOP→START.
- When CE=0, all outputs hold and no writes are accepted.

## Test plan
- Reset: hold RST_N=0 → TXD=1, OE=1, OF=0, BUSY=0, MO_INT=0. Assert RST_N=0 asynchronously mid-DATA → TXD=1 within the same cycle, OE=1 after release.
- Single byte, BIT_DIV=4, CE=1: write 0x90 → TXD is 0 for 4 cycles (start), then bits 0,0,0,0,1,0,0,1 for 4 cycles each, then 1 for 4 cycles. MO_INT pulses once at cycle 2+40. OE=0 for exactly one cycle.
- Back-to-back: write 0x90, 0x3C, 0x7F on consecutive cycles → three frames, 120 cycles total, no idle between stop and start bits. MO_INT asserts only after 0x7F.
- Full/overflow, DEPTH_LOG2=2: write 6 bytes 0x01..0x06 in 6 cycles → the first is popped and the next 4 fill the FIFO, so OF=1 and 0x06 is dropped. The serial output is 0x01..0x05 only.
- Full-plus-pop: with the FIFO full and the STOP period ending, issue a write in the pop cycle → write accepted, OF stays 1, and the byte appears later in the serial order.
- CE gating: CE toggled 1/0 with BIT_DIV=4 → each serial bit lasts 8 CLK cycles. A write presented while CE=0 is ignored.
